// File: rtl/instruction_loader.sv
// instruction_loader: byte-stream write master for the instruction memory.
// Consumes a word-count header byte followed by instruction bytes (high byte
// first), pairs them into 16-bit words and writes them at sequential
// addresses starting at BASE_ADDR, then raises finish.
module instruction_loader #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] new_instruction_address,
    output logic [15:0]           instruction_in,
    output logic                  finish,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_target;
    logic [ADDR_WIDTH:0]   r_words;
    logic [7:0]            r_hi;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_data;
    logic                  r_finish;
    logic                  r_busy;

    logic [ADDR_WIDTH:0]   w_words_inc;
    logic [ADDR_WIDTH:0]   w_target_in;

    // A header of zero stands for a full memory load (2^ADDR_WIDTH words).
    assign w_words_inc = r_words + CW'(1);
    assign w_target_in = (byte_in == 8'h00) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                            : CW'(byte_in);

    // Load sequencer with registered memory-port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= BASE_ADDR;
            r_target <= '0;
            r_words  <= '0;
            r_hi     <= '0;
            r_we     <= 1'b0;
            r_addr   <= BASE_ADDR;
            r_data   <= '0;
            r_finish <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_COUNT;
                        r_words <= '0;
                        r_ptr   <= BASE_ADDR;
                        r_busy  <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (byte_valid) begin
                        r_target <= w_target_in;
                        r_state  <= S_HI;
                    end
                end
                S_HI: begin
                    if (byte_valid) begin
                        r_hi    <= byte_in;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    if (byte_valid) begin
                        r_we    <= 1'b1;
                        r_data  <= {r_hi, byte_in};
                        r_addr  <= r_ptr;
                        r_ptr   <= r_ptr + ADDR_WIDTH'(1);
                        r_words <= w_words_inc;
                        if (w_words_inc == r_target) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_HI;
                        end
                    end
                end
                S_DONE: begin
                    // finish is raised on the first DONE cycle so it trails
                    // the final write strobe by one clock.
                    if (start) begin
                        r_state  <= S_COUNT;
                        r_finish <= 1'b0;
                        r_words  <= '0;
                        r_ptr    <= BASE_ADDR;
                        r_busy   <= 1'b1;
                    end else begin
                        r_finish <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign we                      = r_we;
    assign new_instruction_address = r_addr;
    assign instruction_in          = r_data;
    assign finish                  = r_finish;
    assign busy                    = r_busy;
    assign words_loaded            = r_words;

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader: two instances (BASE_ADDR 0x00 and 0xF0)
// share one stimulus stream; a per-cycle vector table plus directed
// sequences for streaming, full-depth wrap, mid-load start and reset.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st;
    logic        bv;
    logic [7:0]  bin;

    logic        we0, we1;
    logic [7:0]  a0, a1;
    logic [15:0] d0, d1;
    logic        f0, f1;
    logic        b0, b1;
    logic [8:0]  w0, w1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0]  qa0[$], qa1[$];
    logic [15:0] qd0[$], qd1[$];
    int          qc0[$];

    instruction_loader #(.ADDR_WIDTH(8), .BASE_ADDR(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st), .byte_valid(bv), .byte_in(bin),
        .we(we0), .new_instruction_address(a0), .instruction_in(d0),
        .finish(f0), .busy(b0), .words_loaded(w0)
    );

    instruction_loader #(.ADDR_WIDTH(8), .BASE_ADDR(8'hF0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st), .byte_valid(bv), .byte_in(bin),
        .we(we1), .new_instruction_address(a1), .instruction_in(d1),
        .finish(f1), .busy(b1), .words_loaded(w1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: logs every strobe of both instances.
    always @(posedge clk) begin
        #1;
        if (we0) begin
            qa0.push_back(a0);
            qd0.push_back(d0);
            qc0.push_back(cyc);
        end
        if (we1) begin
            qa1.push_back(a1);
            qd1.push_back(d1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        st;
        logic        bv;
        logic [7:0]  b;
        logic        we;
        logic [7:0]  aoff;
        logic [15:0] data;
        logic        fin;
        logic        busy;
        logic [8:0]  words;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [7:0] b);
        st  = s;
        bv  = v;
        bin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic qclear();
        qa0.delete(); qa1.delete(); qd0.delete(); qd1.delete(); qc0.delete();
    endtask

    task automatic chk_status(input string name, input logic fin, input logic bsy, input logic [8:0] wds);
        chk({name, " finish0"}, 32'(f0), 32'(fin));
        chk({name, " finish1"}, 32'(f1), 32'(fin));
        chk({name, " busy0"},   32'(b0), 32'(bsy));
        chk({name, " busy1"},   32'(b1), 32'(bsy));
        chk({name, " words0"},  32'(w0), 32'(wds));
        chk({name, " words1"},  32'(w1), 32'(wds));
    endtask

    task automatic chk_reset(input string name);
        chk({name, " we0"},   32'(we0), 32'd0);
        chk({name, " we1"},   32'(we1), 32'd0);
        chk({name, " addr0"}, 32'(a0),  32'h00);
        chk({name, " addr1"}, 32'(a1),  32'hF0);
        chk({name, " data0"}, 32'(d0),  32'h0);
        chk({name, " data1"}, 32'(d1),  32'h0);
        chk_status(name, 1'b0, 1'b0, 9'd0);
    endtask

    vec_t        tbl [14];
    logic [7:0]  fr  [6];
    logic [7:0]  ea;
    logic [15:0] ed;

    initial begin
        //          st    bv    byte   we    aoff   data      fin   busy  words
        tbl[0]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 9'd0}; // IDLE byte dropped
        tbl[1]  = '{1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 9'd0}; // start+byte: byte dropped
        tbl[2]  = '{1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 9'd0};
        tbl[3]  = '{1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 9'd0};
        tbl[4]  = '{1'b0, 1'b1, 8'h34, 1'b1, 8'h00, 16'h1234, 1'b0, 1'b1, 9'd1};
        tbl[5]  = '{1'b0, 1'b1, 8'hAB, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 9'd1};
        tbl[6]  = '{1'b0, 1'b1, 8'hCD, 1'b1, 8'h01, 16'hABCD, 1'b0, 1'b0, 9'd2};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 9'd2}; // finish one after last we
        tbl[8]  = '{1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 9'd2}; // DONE byte dropped
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 9'd0}; // restart from DONE
        tbl[10] = '{1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 9'd0};
        tbl[11] = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 9'd0};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 16'hFF00, 1'b0, 1'b0, 9'd1};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 9'd1};

        fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h33;
        fr[3] = 8'h44; fr[4] = 8'h55; fr[5] = 8'h66;

        rst_n = 1'b0;
        st    = 1'b0;
        bv    = 1'b0;
        bin   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;

        // ---- per-cycle vector table ----
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].st, tbl[i].bv, tbl[i].b);
            chk($sformatf("row%0d we0", i), 32'(we0), 32'(tbl[i].we));
            chk($sformatf("row%0d we1", i), 32'(we1), 32'(tbl[i].we));
            if (tbl[i].we) begin
                ea = 8'hF0 + tbl[i].aoff;
                chk($sformatf("row%0d addr0", i), 32'(a0), 32'(tbl[i].aoff));
                chk($sformatf("row%0d addr1", i), 32'(a1), 32'(ea));
                chk($sformatf("row%0d data0", i), 32'(d0), 32'(tbl[i].data));
                chk($sformatf("row%0d data1", i), 32'(d1), 32'(tbl[i].data));
            end
            chk_status($sformatf("row%0d", i), tbl[i].fin, tbl[i].busy, tbl[i].words);
        end

        // ---- full-rate stream, 3 words ----
        qclear();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h03);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, fr[i]);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        chk("fr count0", 32'(qa0.size()), 32'd3);
        chk("fr count1", 32'(qa1.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            ed = {fr[2*k], fr[2*k+1]};
            ea = 8'hF0 + 8'(k);
            chk($sformatf("fr addr0[%0d]", k), 32'(qa0[k]), 32'(k));
            chk($sformatf("fr addr1[%0d]", k), 32'(qa1[k]), 32'(ea));
            chk($sformatf("fr data0[%0d]", k), 32'(qd0[k]), 32'(ed));
            chk($sformatf("fr data1[%0d]", k), 32'(qd1[k]), 32'(ed));
        end
        chk("fr spacing01", 32'(qc0[1] - qc0[0]), 32'd2);
        chk("fr spacing12", 32'(qc0[2] - qc0[1]), 32'd2);
        chk_status("fr end", 1'b1, 1'b0, 9'd3);

        // ---- header 0: full 256-word load with address wrap ----
        qclear();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, 8'(i));
            step(1'b0, 1'b1, 8'(i) ^ 8'hA5);
            if (i == 254) chk_status("full w255", 1'b0, 1'b1, 9'd255);
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("full count0", 32'(qa0.size()), 32'd256);
        chk("full count1", 32'(qa1.size()), 32'd256);
        for (int k = 0; k < 256; k++) begin
            ea = 8'hF0 + 8'(k);
            ed = {8'(k), 8'(k) ^ 8'hA5};
            chk($sformatf("full addr0[%0d]", k), 32'(qa0[k]), 32'(k));
            chk($sformatf("full addr1[%0d]", k), 32'(qa1[k]), 32'(ea));
            chk($sformatf("full data0[%0d]", k), 32'(qd0[k]), 32'(ed));
            chk($sformatf("full data1[%0d]", k), 32'(qd1[k]), 32'(ed));
        end
        chk_status("full end", 1'b1, 1'b0, 9'd256);

        // ---- start pulses mid-load are ignored ----
        qclear();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h12);
        step(1'b1, 1'b1, 8'h34);
        step(1'b1, 1'b0, 8'h00);
        chk_status("mid start", 1'b0, 1'b1, 9'd1);
        step(1'b0, 1'b1, 8'hAB);
        step(1'b0, 1'b1, 8'hCD);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("ms count0", 32'(qa0.size()), 32'd2);
        chk("ms data0[0]", 32'(qd0[0]), 32'h1234);
        chk("ms data0[1]", 32'(qd0[1]), 32'hABCD);
        chk("ms addr1[1]", 32'(qa1[1]), 32'hF1);
        chk_status("ms end", 1'b1, 1'b0, 9'd2);

        // ---- reset after 3 of 5 words ----
        qclear();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h05);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 8'h40 + 8'(k));
            step(1'b0, 1'b1, 8'h80 + 8'(k));
        end
        #2;
        chk("rst we before", 32'(we0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        rst_n = 1'b1;
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'h33);
        step(1'b0, 1'b1, 8'h44);
        step(1'b0, 1'b0, 8'h00);
        chk("rst count0", 32'(qa0.size()), 32'd3);
        chk("rst count1", 32'(qa1.size()), 32'd3);
        chk("rst data0[2]", 32'(qd0[2]), 32'h4282);
        chk_status("rst idle", 1'b0, 1'b0, 9'd0);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'hBE);
        step(1'b0, 1'b1, 8'hEF);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("post count0", 32'(qa0.size()), 32'd4);
        chk("post addr0", 32'(qa0[3]), 32'h00);
        chk("post addr1", 32'(qa1[3]), 32'hF0);
        chk("post data0", 32'(qd0[3]), 32'hBEEF);
        chk_status("post end", 1'b1, 1'b0, 9'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Write-side master for the 256 x 16 instruction memory.
- Accepts a byte stream (typically from a UART receiver) carrying a word-count header followed by instruction bytes, high byte first.
- Assembles each pair of bytes into a 16-bit word and drives the memory write port (we, new_instruction_address, instruction_in) at sequential addresses.
- Raises finish when the load completes, which releases the CPU to fetch.

Parameters:
- ADDR_WIDTH, 8, width of new_instruction_address; memory depth is 2^ADDR_WIDTH.
- BASE_ADDR, 0, address that receives the first loaded word.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- byte_valid  input  1  byte_in is valid this cycle; one byte is consumed per asserted cycle.
- byte_in  input  8  stream byte.
- we  output  1  memory write strobe; one-cycle pulse per word.
- new_instruction_address  output  ADDR_WIDTH  write address; valid while we=1.
- instruction_in  output  16  write data; valid while we=1.
- finish  output  1  high in DONE; load complete.
- busy  output  1  high in COUNT, HI, LO.
- words_loaded  output  ADDR_WIDTH+1  number of words written in the current or last load.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. we=0, new_instruction_address=BASE_ADDR, instruction_in=0, finish=0, busy=0, words_loaded=0, internal count and high-byte registers cleared. Reset mid-load abandons the load; words already written stay in memory and no further we is issued.
- All outputs are registered.
- States:
  - IDLE: start=1 -> COUNT; words_loaded cleared; address pointer = BASE_ADDR.
  - COUNT: on byte_valid, latch target = byte_in, with 0 meaning 2^ADDR_WIDTH (256). -> HI.
  - HI: on byte_valid, latch byte_in as hi byte -> LO.
  - LO: on byte_valid, form word {hi, byte_in}. Next cycle: we=1, instruction_in=word, new_instruction_address=pointer. Same edge: pointer+1 (wraps mod 2^ADDR_WIDTH), words_loaded+1. If words_loaded+1 == target -> DONE, else -> HI.
  - DONE: finish=1, busy=0, we=0. start=1 -> COUNT, with finish dropping the next cycle and words_loaded cleared.
- Bytes without byte_valid are ignored. Bytes arriving in IDLE or DONE are dropped.
- Back-to-back writes: a byte accepted in HI on the same cycle the previous we is high is captured normally. Full-rate streaming (byte_valid every cycle) is supported with no stalls; we pulses every second cycle.
- start while busy is ignored. start and byte_valid in the same IDLE cycle: the byte is dropped and the state goes to COUNT.
- Address wrap: with BASE_ADDR!=0 and target=256, the pointer wraps 255->0 and every location is written exactly once.
- Latency: from LO byte accepted to we high is 1 cycle. finish rises 1 cycle after the last we.
- The loader has no backpressure; the byte source must not exceed one byte per cycle.

Test Plan:
- Reset then start, bytes 02,12,34,AB,CD -> we pulses: addr 0 data 1234, addr 1 data ABCD; finish=1 one cycle after the 2nd we; words_loaded=2.
- Full-rate stream (byte_valid every cycle), header 03, data 6 bytes -> 3 we pulses spaced 2 cycles apart, addresses 0,1,2, no byte lost.
- Header 00, 512 bytes with BASE_ADDR=8'hF0 -> 256 writes; addresses F0..FF then 00..EF; finish set; words_loaded=256.
- rst_n low after 3 of 5 words written -> all outputs reset immediately; no further we; bytes afterwards ignored until start.
- start pulsed mid-load, and bytes sent while in IDLE -> start ignored, load completes normally; IDLE bytes produce no we and no state change.
- From DONE, start plus a new 1-word stream (01,FF,00) -> finish drops, one write at addr BASE_ADDR with data FF00, finish rises again.
